// File: rtl/button_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : button_command_sequencer
// Description : Captures button pulses, round-robin serialises them into a
//               small command FIFO and hands codes to the game FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module button_command_sequencer #(
    parameter int N_BTN  = 12,
    parameter int DEPTH  = 4,
    parameter int CODE_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         btn_pulse,
    input  logic                     game_busy,
    input  logic                     cmd_ready,
    output logic                     cmd_valid,
    output logic [CODE_W-1:0]        cmd_code,
    output logic                     block_controller,
    output logic [N_BTN-1:0]         pending,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     drop_flag
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [N_BTN-1:0]   r_pending;
    logic [CODE_W-1:0]  r_last_grant;
    logic [CODE_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_block;
    logic               r_drop;

    logic [N_BTN-1:0]   w_hi_mask;
    logic [N_BTN-1:0]   w_hi_req;
    logic [N_BTN-1:0]   w_src;
    logic [N_BTN-1:0]   w_grant_vec;
    logic [CODE_W-1:0]  w_grant_idx;
    logic               w_can_push;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [c_CNT_W-1:0] w_count_next;

    assign w_can_push = (r_count < c_CNT_W'(DEPTH));
    assign w_push     = w_can_push && (|r_pending);
    assign w_pop      = cmd_valid && cmd_ready;

    // Round robin: lanes above last_grant win first, otherwise wrap to lane 0.
    always_comb begin
        w_hi_mask   = '0;
        w_grant_idx = '0;
        w_grant_vec = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_hi_mask[i] = (CODE_W'(i) > r_last_grant);
        end
        w_hi_req = r_pending & w_hi_mask;
        w_src    = (|w_hi_req) ? w_hi_req : r_pending;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (w_src[i]) begin
                w_grant_idx = CODE_W'(i);
            end
        end
        if (w_push) begin
            w_grant_vec[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CNT_W'(1);
        end
    end

    // A pulse on a lane still waiting (and not being granted now) is merged and lost.
    assign w_drop = |(btn_pulse & r_pending & ~w_grant_vec);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= '0;
            r_last_grant <= CODE_W'(N_BTN - 1);
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_block      <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_grant_vec) | btn_pulse;
            r_count   <= w_count_next;
            r_block   <= game_busy || (w_count_next >= c_CNT_W'(DEPTH - 1));
            if (w_drop) begin
                r_drop <= 1'b1;
            end
            if (w_push) begin
                r_last_grant <= w_grant_idx;
                r_wr_ptr     <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_grant_idx;
        end
    end

    assign cmd_valid        = (r_count != '0);
    assign cmd_code         = cmd_valid ? r_mem[r_rd_ptr] : '0;
    assign block_controller = r_block;
    assign pending          = r_pending;
    assign fifo_count       = r_count;
    assign drop_flag        = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_button_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_command_sequencer
// Description : Directed table, corner sequences and random traffic against a
//               queue-based reference model of the command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_command_sequencer;

    localparam int N_BTN  = 12;
    localparam int DEPTH  = 4;
    localparam int CODE_W = 4;

    logic              clk;
    logic              reset;
    logic [N_BTN-1:0]  btn_pulse;
    logic              game_busy;
    logic              cmd_ready;
    logic              cmd_valid;
    logic [CODE_W-1:0] cmd_code;
    logic              block_controller;
    logic [N_BTN-1:0]  pending;
    logic [2:0]        fifo_count;
    logic              drop_flag;

    button_command_sequencer #(.N_BTN(N_BTN), .DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_pulse        (btn_pulse),
        .game_busy        (game_busy),
        .cmd_ready        (cmd_ready),
        .cmd_valid        (cmd_valid),
        .cmd_code         (cmd_code),
        .block_controller (block_controller),
        .pending          (pending),
        .fifo_count       (fifo_count),
        .drop_flag        (drop_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int               m_q[$];
    logic [N_BTN-1:0] m_pend;
    int               m_last;
    logic             m_blk;
    logic             m_drop;

    int dq[$];

    typedef struct {
        logic              r;
        logic [N_BTN-1:0]  p;
        logic              b;
        logic              rd;
        logic              v;
        logic [CODE_W-1:0] code;
        logic [2:0]        cnt;
        logic              blk;
        logic [N_BTN-1:0]  pend;
        logic              drop;
    } vec_t;

    vec_t tbl [14];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_step(input logic r, input logic [N_BTN-1:0] p,
                              input logic b, input logic rd);
        int g;
        int l;
        if (r) begin
            m_q.delete();
            m_pend = '0;
            m_last = N_BTN - 1;
            m_blk  = 1'b0;
            m_drop = 1'b0;
        end else begin
            g = -1;
            if (m_q.size() < DEPTH) begin
                for (int k = 1; k <= N_BTN; k++) begin
                    l = (m_last + k) % N_BTN;
                    if (g < 0 && m_pend[l]) g = l;
                end
            end
            if (m_q.size() != 0 && rd) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back(g);
                m_last = g;
            end
            for (int i = 0; i < N_BTN; i++) begin
                if (p[i] && m_pend[i] && i != g) m_drop = 1'b1;
            end
            for (int i = 0; i < N_BTN; i++) begin
                m_pend[i] = (m_pend[i] && i != g) || p[i];
            end
            m_blk = b || (m_q.size() >= DEPTH - 1);
        end
    endtask

    task automatic check_model();
        chk("model_valid", 32'(cmd_valid), 32'(m_q.size() != 0));
        chk("model_code", 32'(cmd_code), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk("model_count", 32'(fifo_count), 32'(m_q.size()));
        chk("model_block", 32'(block_controller), 32'(m_blk));
        chk("model_pending", 32'(pending), 32'(m_pend));
        chk("model_drop", 32'(drop_flag), 32'(m_drop));
    endtask

    // One clock: drive, note any handshake completing at this edge, advance model.
    task automatic cycle(input logic r, input logic [N_BTN-1:0] p,
                         input logic b, input logic rd);
        reset     = r;
        btn_pulse = p;
        game_busy = b;
        cmd_ready = rd;
        #1;
        if (!r && cmd_valid && rd) dq.push_back(int'(cmd_code));
        model_step(r, p, b, rd);
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        logic [N_BTN-1:0] rp;
        int ready_pct;
        reset = 1'b1; btn_pulse = '0; game_busy = 1'b0; cmd_ready = 1'b0;
        m_pend = '0; m_last = N_BTN - 1; m_blk = 1'b0; m_drop = 1'b0;

        //          r     p        b     rd    v     code   cnt   blk   pend     drop
        tbl[0]  = '{1'b1, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 12'h000, 1'b0};
        tbl[1]  = '{1'b0, 12'h010, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 12'h010, 1'b0};
        tbl[2]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 4'd4,  3'd1, 1'b0, 12'h000, 1'b0};
        tbl[3]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 12'h000, 1'b0};
        tbl[4]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 12'h000, 1'b0};
        tbl[5]  = '{1'b1, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 12'h000, 1'b0};
        tbl[6]  = '{1'b0, 12'h805, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 12'h805, 1'b0};
        tbl[7]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 4'd0,  3'd1, 1'b0, 12'h804, 1'b0};
        tbl[8]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 4'd2,  3'd1, 1'b0, 12'h800, 1'b0};
        tbl[9]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 4'd11, 3'd1, 1'b0, 12'h000, 1'b0};
        tbl[10] = '{1'b0, 12'h801, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 12'h801, 1'b0};
        tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 4'd0,  3'd1, 1'b0, 12'h800, 1'b0};
        tbl[12] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 4'd11, 3'd1, 1'b0, 12'h000, 1'b0};
        tbl[13] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 12'h000, 1'b0};

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].r, tbl[i].p, tbl[i].b, tbl[i].rd);
            chk($sformatf("tbl%0d_valid", i), 32'(cmd_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_code", i), 32'(cmd_code), 32'(tbl[i].code));
            chk($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_block", i), 32'(block_controller), 32'(tbl[i].blk));
            chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
            chk($sformatf("tbl%0d_drop", i), 32'(drop_flag), 32'(tbl[i].drop));
        end

        // Backpressure: five presses into a four-deep queue
        cycle(1'b1, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) cycle(1'b0, 12'h001 << i, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("bp_count", 32'(fifo_count), 32'd4);
        chk("bp_code", 32'(cmd_code), 32'd1);
        chk("bp_block", 32'(block_controller), 32'd1);
        chk("bp_pending", 32'(pending), 32'h020);

        // Second press on the stalled lane is lost
        cycle(1'b0, 12'h020, 1'b0, 1'b0);
        chk("drop_set", 32'(drop_flag), 32'd1);
        chk("drop_pending", 32'(pending), 32'h020);
        dq.delete();
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("bp_delivered_n", 32'(dq.size()), 32'd5);
        for (int i = 0; i < dq.size() && i < 5; i++)
            chk($sformatf("bp_order%0d", i), 32'(dq[i]), 32'(i + 1));

        // Busy hold-off
        dq.delete();
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, (k == 3) ? 12'h080 : 12'h000, 1'b1, 1'b1);
            chk($sformatf("busy_block%0d", k), 32'(block_controller), 32'd1);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("busy_release", 32'(block_controller), 32'd0);
        chk("busy_delivered_n", 32'(dq.size()), 32'd1);
        if (dq.size() > 0) chk("busy_delivered", 32'(dq[0]), 32'd7);
        chk("drop_sticky", 32'(drop_flag), 32'd1);

        // Reset mid-operation
        cycle(1'b0, 12'h007, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 12'h0C0, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        chk("pre_rst_pending", 32'(pending), 32'h0C0);
        cycle(1'b1, '0, 1'b0, 1'b0);
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_block", 32'(block_controller), 32'd0);
        chk("rst_drop", 32'(drop_flag), 32'd0);
        cycle(1'b0, 12'h008, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("post_rst_valid", 32'(cmd_valid), 32'd1);
        chk("post_rst_code", 32'(cmd_code), 32'd3);

        // Random traffic with varying ready density
        for (int blk = 0; blk < 8; blk++) begin
            ready_pct = (blk % 4) * 30 + 5;
            for (int c = 0; c < 250; c++) begin
                rp = '0;
                for (int i = 0; i < N_BTN; i++) rp[i] = ($urandom_range(0, 9) == 0);
                cycle($urandom_range(0, 199) == 0, rp, $urandom_range(0, 9) < 2,
                      $urandom_range(0, 99) < ready_pct);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
